// File: rtl/ip_pkg.sv
// Shared IPv4 constants, framer state encoding and the ones-complement fold
// used by header checksum logic on both the TX and RX sides.
package ip_pkg;

  localparam logic [3:0]  IPV4_VERSION     = 4'd4;
  localparam logic [3:0]  IPV4_IHL         = 4'd5;
  localparam int          IPV4_HDR_WORDS   = 5;
  localparam logic [7:0]  IP_PROT_UDP      = 8'd17;
  localparam logic [15:0] ETH_TYPE_IPV4    = 16'h0800;
  localparam logic [15:0] IPV4_MAX_PAYLOAD = 16'd65515;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HDR  = 2'd2;
  localparam logic [1:0] S_PAY  = 2'd3;

  // Adds the carry nibble back into the low 16 bits; the result may still carry.
  function automatic logic [19:0] ones_fold(input logic [19:0] x);
    return {4'h0, x[15:0]} + {16'h0000, x[19:16]};
  endfunction

endpackage

// File: rtl/ip_hdr_checksum.sv
// Combinational IPv4 header checksum: ones-complement sum of ten 16-bit words,
// inverted. Word 0 sits in the top 16 bits of i_hdr.
module ip_hdr_checksum
  import ip_pkg::*;
(
  input  logic [159:0] i_hdr,
  output logic [15:0]  o_csum
);

  logic [19:0] w_sum;
  logic [15:0] w_folded;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 10; i++) begin
      w_sum = w_sum + {4'h0, i_hdr[i*16 +: 16]};
    end
    w_folded = 16'(ones_fold(ones_fold(w_sum)));
  end

  assign o_csum = ~w_folded;

endmodule

// File: rtl/network_layer_tx.sv
// IPv4 transmit framer: 5-word header followed by the payload stream.
// Define IPTX_CHECKSUM_EN to add the CALC cycle and a real header checksum.
module network_layer_tx
  import ip_pkg::*;
#(
  parameter logic [7:0] TTL = 8'd64,
  parameter bit         DF  = 1'b1,
  parameter logic [7:0] TOS = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_req,
  input  logic [15:0] tx_len,
  input  logic [7:0]  tx_prot,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic        tx_busy,
  output logic        tx_err,
  output logic [15:0] packet_id_o,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        mac_op_st,
  output logic        mac_op,
  output logic        mac_op_end,
  output logic [31:0] mac_data,
  input  logic        mac_rdy
);

  logic [1:0]  r_state;
  logic [15:0] r_len;
  logic [7:0]  r_prot;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_id;
  logic [15:0] r_rem;
  logic [2:0]  r_hidx;
  logic        r_busy;
  logic        r_err;
  logic        r_op;
  logic        r_st;
  logic        r_end;
  logic [31:0] r_data;

  logic [15:0] w_total;
  logic [15:0] w_csum_field;
  logic [31:0] w_hdr0;
  logic [31:0] w_hdr1;
  logic [31:0] w_hdr2;
  logic [31:0] w_hdr_word;
  logic        w_load_ok;
  logic        w_pl_ready;

  function automatic logic [31:0] last_mask(input logic [31:0] d, input logic [1:0] m);
    case (m)
      2'd1:    return {d[31:24], 24'h000000};
      2'd2:    return {d[31:16], 16'h0000};
      2'd3:    return {d[31:8], 8'h00};
      default: return d;
    endcase
  endfunction

  assign w_total = r_len + 16'd20;
  assign w_hdr0  = {IPV4_VERSION, IPV4_IHL, TOS, w_total};
  assign w_hdr1  = {r_id, 1'b0, DF, 1'b0, 13'h0000};
  assign w_hdr2  = {TTL, r_prot, w_csum_field};

`ifdef IPTX_CHECKSUM_EN
  logic [15:0] r_csum;
  logic [15:0] w_csum;

  ip_hdr_checksum u_csum (
    .i_hdr  ({w_hdr0, w_hdr1, TTL, r_prot, 16'h0000, r_src, r_dst}),
    .o_csum (w_csum)
  );

  assign w_csum_field = r_csum;
`else
  assign w_csum_field = 16'h0000;
`endif

  always_comb begin
    w_hdr_word = w_hdr0;
    case (r_hidx)
      3'd1:    w_hdr_word = w_hdr1;
      3'd2:    w_hdr_word = w_hdr2;
      3'd3:    w_hdr_word = r_src;
      3'd4:    w_hdr_word = r_dst;
      default: w_hdr_word = w_hdr0;
    endcase
  end

  // Output register may take a new word when empty or draining this cycle.
  assign w_load_ok  = !r_op || mac_rdy;
  assign w_pl_ready = (r_state == S_PAY) && (r_rem != 16'd0) && w_load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_prot  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_id    <= '0;
      r_rem   <= '0;
      r_hidx  <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_op    <= 1'b0;
      r_st    <= 1'b0;
      r_end   <= 1'b0;
      r_data  <= '0;
`ifdef IPTX_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      if (r_op && mac_rdy) begin
        r_op  <= 1'b0;
        r_st  <= 1'b0;
        r_end <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (tx_req) begin
            if (tx_len > IPV4_MAX_PAYLOAD) begin
              r_err <= 1'b1;
            end else begin
              r_len   <= tx_len;
              r_prot  <= tx_prot;
              r_src   <= src_ip;
              r_dst   <= dst_ip;
              r_rem   <= 16'(({1'b0, tx_len} + 17'd3) >> 2);
              r_hidx  <= '0;
              r_busy  <= 1'b1;
`ifdef IPTX_CHECKSUM_EN
              r_state <= S_CALC;
`else
              r_state <= S_HDR;
`endif
            end
          end
        end
`ifdef IPTX_CHECKSUM_EN
        S_CALC: begin
          r_csum  <= w_csum;
          r_state <= S_HDR;
        end
`endif
        S_HDR: begin
          if (w_load_ok) begin
            r_data <= w_hdr_word;
            r_op   <= 1'b1;
            r_st   <= (r_hidx == 3'd0);
            r_end  <= (r_hidx == 3'd4) && (r_rem == 16'd0);
            r_hidx <= r_hidx + 3'd1;
            if (r_hidx == 3'd4) begin
              r_state <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (pl_valid && w_pl_ready) begin
            r_data <= (r_rem == 16'd1) ? last_mask(pl_data, r_len[1:0]) : pl_data;
            r_op   <= 1'b1;
            r_st   <= 1'b0;
            r_end  <= (r_rem == 16'd1);
            r_rem  <= r_rem - 16'd1;
          end
          // A zero-payload frame also finishes here, after header word 4 drains.
          if (r_op && mac_rdy && r_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_id    <= r_id + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_busy     = r_busy;
  assign tx_err      = r_err;
  assign packet_id_o = r_id;
  assign pl_ready    = w_pl_ready;
  assign mac_op      = r_op;
  assign mac_op_st   = r_st;
  assign mac_op_end  = r_end;
  assign mac_data    = r_data;

endmodule

// File: tb/tb_network_layer_tx.sv
// Directed bench for network_layer_tx; expected headers are built locally,
// with the checksum field depending on IPTX_CHECKSUM_EN.
module tb_network_layer_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_req;
  logic [15:0] tx_len;
  logic [7:0]  tx_prot;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic        tx_busy;
  logic        tx_err;
  logic [15:0] packet_id_o;
  logic [31:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        mac_op_st;
  logic        mac_op;
  logic        mac_op_end;
  logic [31:0] mac_data;
  logic        mac_rdy;

`ifdef IPTX_CHECKSUM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  network_layer_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_req      (tx_req),
    .tx_len      (tx_len),
    .tx_prot     (tx_prot),
    .src_ip      (src_ip),
    .dst_ip      (dst_ip),
    .tx_busy     (tx_busy),
    .tx_err      (tx_err),
    .packet_id_o (packet_id_o),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .mac_op_st   (mac_op_st),
    .mac_op      (mac_op),
    .mac_op_end  (mac_op_end),
    .mac_data    (mac_data),
    .mac_rdy     (mac_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pay_word(input int i);
    return {8'(i + 1), 8'h5A, 8'hC3, 8'hFF};
  endfunction

  function automatic logic [15:0] exp_csum(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3,
                                           input logic [31:0] w4);
    logic [31:0] s;
    s = w0[31:16] + w0[15:0] + w1[31:16] + w1[15:0] + w2[31:16]
      + w3[31:16] + w3[15:0] + w4[31:16] + w4[15:0];
    while (s[31:16] != 16'h0000) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    return ~s[15:0];
  endfunction

  // Transfer monitor: samples on the falling edge, between active edges.
  logic [31:0] cap_d[$];
  bit          cap_st[$];
  bit          cap_end[$];
  bit          done;
  bit          pl_seen;
  bit          first_seen;
  int          first_cyc;
  int          pl_idx;
  bit          prev_stall = 1'b0;
  logic [34:0] prev_out;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check("hold_while_stalled", {mac_op, mac_op_st, mac_op_end, mac_data}, prev_out);
      prev_stall = mac_op && !mac_rdy;
      prev_out   = {mac_op, mac_op_st, mac_op_end, mac_data};
      if (mac_op && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (mac_op && mac_rdy) begin
        cap_d.push_back(mac_data);
        cap_st.push_back(mac_op_st);
        cap_end.push_back(mac_op_end);
        if (mac_op_end) done = 1'b1;
      end
      if (pl_ready) pl_seen = 1'b1;
      if (pl_valid && pl_ready) pl_idx++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // mode 0: mac_rdy and pl_valid held high; mode 1: mac_rdy toggles, pl_valid random.
  task automatic send(input logic [15:0] len, input logic [7:0] prot, input logic [31:0] src,
                      input logic [31:0] dst, input logic [15:0] id, input int mode,
                      input int abort_at, input bit busy_req);
    logic [31:0] exp_q[$];
    logic [31:0] w0, w1, w2, pw;
    logic [15:0] nid;
    int n, req_cyc, k;
    n  = (int'(len) + 3) / 4;
    w0 = {8'h45, 8'h00, len + 16'd20};
    w1 = {id, 16'h4000};
    w2 = {8'd64, prot, 16'h0000};
`ifdef IPTX_CHECKSUM_EN
    w2[15:0] = exp_csum(w0, w1, w2, src, dst);
`endif
    exp_q = '{w0, w1, w2, src, dst};
    for (int i = 0; i < n; i++) begin
      pw = pay_word(i);
      if (i == n - 1) begin
        case (len[1:0])
          2'd1: pw = pw & 32'hFF00_0000;
          2'd2: pw = pw & 32'hFFFF_0000;
          2'd3: pw = pw & 32'hFFFF_FF00;
          default: ;
        endcase
      end
      exp_q.push_back(pw);
    end
    cap_d.delete(); cap_st.delete(); cap_end.delete();
    done = 1'b0; pl_idx = 0; first_seen = 1'b0; pl_seen = 1'b0;
    tx_len = len; tx_prot = prot; src_ip = src; dst_ip = dst; tx_req = 1'b1;
    @(posedge clk); #1;
    req_cyc = cyc;
    tx_req  = 1'b0;
    k = 0;
    while (!done && k < 400) begin
      mac_rdy  = (mode == 1) ? k[0] : 1'b1;
      pl_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      pl_data  = pay_word(pl_idx);
      tx_req   = busy_req && (k == 2);
      if (abort_at >= 0 && cap_d.size() >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset", {tx_busy, tx_err, packet_id_o, pl_ready, mac_op,
                                   mac_op_st, mac_op_end, mac_data}, 64'h0);
        tx_req = 1'b0; pl_valid = 1'b0; mac_rdy = 1'b1;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    tx_req = 1'b0; pl_valid = 1'b0; mac_rdy = 1'b1;
    check("frame_done", done, 1);
    check("latency", first_cyc - req_cyc, LAT);
    check("n_transfers", cap_d.size(), exp_q.size());
    for (int i = 0; i < cap_d.size() && i < exp_q.size(); i++) begin
      check($sformatf("word%0d", i), cap_d[i], exp_q[i]);
      check($sformatf("st%0d", i), cap_st[i], i == 0);
      check($sformatf("end%0d", i), cap_end[i], i == exp_q.size() - 1);
    end
    nid = id + 16'd1;
    check("busy_after", tx_busy, 0);
    check("id_after", packet_id_o, nid);
  endtask

  initial begin
    int ops;
    rst_n = 1'b0; tx_req = 1'b0; tx_len = '0; tx_prot = '0; src_ip = '0; dst_ip = '0;
    pl_data = '0; pl_valid = 1'b0; mac_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tx_busy, tx_err, packet_id_o, pl_ready, mac_op,
                            mac_op_st, mac_op_end, mac_data}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference checksum vector
    send(16'd95, 8'd17, 32'hC0A80001, 32'hC0A800C7, 16'h0000, 0, -1, 1'b0);
    check("t1_hdr0", cap_d[0], 32'h45000073);
    check("t1_hdr1", cap_d[1], 32'h00004000);
`ifdef IPTX_CHECKSUM_EN
    check("t1_hdr2", cap_d[2], 32'h4011B861);
`else
    check("t1_hdr2", cap_d[2], 32'h40110000);
`endif
    check("t1_last", cap_d[28], 32'h185AC300);

    // Back-pressure, 8 words, last keeps two bytes
    send(16'd30, 8'd17, 32'h0A000001, 32'h0A000002, 16'h0001, 1, -1, 1'b0);

    // Zero payload
    send(16'd0, 8'd17, 32'h01020304, 32'h05060708, 16'h0002, 0, -1, 1'b0);
    check("t3_total_len", cap_d[0][15:0], 16'h0014);
    check("t3_pl_ready_seen", pl_seen, 0);

    // Oversize request is rejected
    tx_len = 16'd65516; tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
    check("rej_err_pulse", tx_err, 1);
    check("rej_busy", tx_busy, 0);
    ops = 0;
    repeat (4) begin
      @(posedge clk); #1;
      ops += int'(mac_op) + int'(tx_busy);
    end
    check("rej_err_cleared", tx_err, 0);
    check("rej_no_activity", ops, 0);
    check("rej_id", packet_id_o, 16'h0003);

    // ID wrap, with a stray request while busy
    force dut.r_id = 16'hFFFF;
    #1;
    release dut.r_id;
    check("id_forced", packet_id_o, 16'hFFFF);
    send(16'd10, 8'd17, 32'hAC100001, 32'hAC100002, 16'hFFFF, 0, -1, 1'b1);
    check("wrap_hdr1_ffff", cap_d[1], 32'hFFFF4000);
    send(16'd10, 8'd17, 32'hAC100001, 32'hAC100002, 16'h0000, 0, -1, 1'b0);
    check("wrap_hdr1_0000", cap_d[1], 32'h00004000);

    // Reset during payload word 3, then a clean packet
    send(16'd40, 8'd6, 32'h0B000001, 32'h0B000002, 16'h0001, 0, 8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_id", packet_id_o, 16'h0000);
    send(16'd13, 8'd17, 32'h0B000001, 32'h0B000002, 16'h0000, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
